// File: rtl/pipeline_pkg.sv
// Shared constants and the per-chunk adder used by the pipelined add/subtract unit.
// Also provides the elaboration check that WIDTH splits evenly into STAGES chunks.
`ifndef PIPELINE_PKG_SV
`define PIPELINE_PKG_SV

`define PIPELINE_ASSERT_DIVISIBLE(W, S) \
   if (((W) % (S)) != 0) begin : g_bad_width \
      $error("pipeline_addsub: WIDTH must be a multiple of STAGES"); \
   end

package pipeline_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;
   localparam int MAX_STAGES = 8;
   localparam int MAX_CHUNK  = 64;

   // Callers zero-extend narrower chunks, so the carry lands at bit CHUNK of the result.
   function automatic logic [MAX_CHUNK:0] chunk_add(input logic [MAX_CHUNK-1:0] a,
                                                    input logic [MAX_CHUNK-1:0] b,
                                                    input logic                 cin);
      return {1'b0, a} + {1'b0, b} + {{MAX_CHUNK{1'b0}}, cin};
   endfunction

endpackage

`endif

// File: rtl/pipe_stage_ctl.sv
// Valid/allowin handshake for one pipeline stage, with per-stage stall and flush.
module pipe_stage_ctl (
   input  logic clk,
   input  logic rst,
   input  logic prev_valid_i,
   input  logic suspend_i,
   input  logic refresh_i,
   input  logic next_allowin_i,
   output logic allowin_o,
   output logic to_next_valid_o
);

   logic valid_q;
   logic valid_d;
   logic ready_go;

   // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
   always_comb begin
      ready_go        = !suspend_i;
      allowin_o       = !valid_q || (ready_go && next_allowin_i);
      to_next_valid_o = valid_q && ready_go;
      valid_d         = allowin_o ? prev_valid_i : valid_q;
   end

   // NOTE: state registers use non-blocking assignment so all stages update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || refresh_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/pipeline_addsub.sv
// WIDTH-bit add/subtract resolved one CHUNK per stage; unconsumed operand bits ride along
// with the partial sum so later stages never look at the live input ports.
module pipeline_addsub
   import pipeline_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              validin,
   output logic              in_allow,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              carry_in,
   input  logic              sub,
   input  logic              out_allow,
   input  logic [STAGES-1:0] suspend,
   input  logic [STAGES-1:0] refresh,
   output logic              validout,
   output logic [WIDTH-1:0]  sum_out,
   output logic              carry_out,
   output logic              overflow
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int CW    = CHUNK + 1;

   `PIPELINE_ASSERT_DIVISIBLE(WIDTH, STAGES)

   if (STAGES < 1 || STAGES > MAX_STAGES || CHUNK > MAX_CHUNK) begin : g_bad_params
      $error("pipeline_addsub: STAGES must be 1..8 and CHUNK at most MAX_CHUNK");
   end

   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   // Subtraction as a + ~b + ~borrow_in, so carry_out reads 1 when no borrow occurred.
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~carry_in : carry_in;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * CHUNK;
      localparam int BW = WIDTH - LO;
      localparam bit LAST = (s == STAGES - 1);

      logic             prev_valid;
      logic             next_allowin;
      logic             allowin;
      logic             tnv;
      logic             load;
      logic [WIDTH-1:0] acc_in;
      logic [WIDTH-1:0] acc_d;
      logic [WIDTH-1:0] acc_q;
      logic [BW-1:0]    b_in;
      logic             c_in;
      logic             c_d;
      logic             c_q;
      logic [CHUNK:0]   add_res;

      // acc holds the finished sum below LO and the untouched operand A above it.
      if (s == 0) begin : g_first
         assign prev_valid = validin;
         assign acc_in     = a;
         assign b_in       = b_eff;
         assign c_in       = c_eff;
      end else begin : g_next
         assign prev_valid = g_stage[s-1].tnv;
         assign acc_in     = g_stage[s-1].acc_q;
         assign b_in       = g_stage[s-1].g_carry.b_hi_q;
         assign c_in       = g_stage[s-1].c_q;
      end

      if (LAST) begin : g_tail
         assign next_allowin = out_allow;
      end else begin : g_body
         assign next_allowin = g_stage[s+1].allowin;
      end

      pipe_stage_ctl u_ctl (
         .clk             (clk),
         .rst             (rst),
         .prev_valid_i    (prev_valid),
         .suspend_i       (suspend[s]),
         .refresh_i       (refresh[s]),
         .next_allowin_i  (next_allowin),
         .allowin_o       (allowin),
         .to_next_valid_o (tnv)
      );

      assign load    = prev_valid && allowin;
      assign add_res = CW'(chunk_add(MAX_CHUNK'(acc_in[LO +: CHUNK]), MAX_CHUNK'(b_in[CHUNK-1:0]), c_in));

      always_comb begin
         acc_d              = acc_in;
         acc_d[LO +: CHUNK] = add_res[CHUNK-1:0];
         c_d                = add_res[CHUNK];
      end

      // NOTE: intermediate data registers are qualified by valid, so only the visible outputs need a reset.
      always_ff @(posedge clk) begin
         if (LAST && rst) begin
            acc_q <= '0;
            c_q   <= 1'b0;
         end else if (load) begin
            acc_q <= acc_d;
            c_q   <= c_d;
         end
      end

      if (!LAST) begin : g_carry
         logic [BW-CHUNK-1:0] b_hi_q;

         always_ff @(posedge clk) begin
            if (load) begin
               b_hi_q <= b_in[BW-1:CHUNK];
            end
         end
      end else begin : g_result
         logic ovf_d;
         logic ovf_q;

         assign ovf_d = (acc_in[WIDTH-1] == b_in[BW-1]) && (add_res[CHUNK-1] != acc_in[WIDTH-1]);

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (load) begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign in_allow  = g_stage[0].allowin;
   assign validout  = g_stage[STAGES-1].tnv;
   assign sum_out   = g_stage[STAGES-1].acc_q;
   assign carry_out = g_stage[STAGES-1].c_q;
   assign overflow  = g_stage[STAGES-1].g_result.ovf_q;

endmodule

// File: tb/tb_pipeline_addsub.sv
// Scoreboard bench: the driver pushes reference results on acceptance, monitors pop on output handshake.
// Covers the 32/4 default plus 64/8 and 16/1 variants running random traffic in parallel.
module tb_pipeline_addsub;

   localparam int W = 32;
   localparam int S = 4;

   typedef struct {
      logic [63:0] sum;
      logic        co;
      logic        ov;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: whole-word unsigned arithmetic for sum/carry, signed integers for overflow.
   function automatic exp_t model(input int w, input logic [63:0] ua, input logic [63:0] ub,
                                  input logic ci, input logic sb, input int acc);
      exp_t m;
      logic [63:0] mask;
      logic [65:0] x, y, r;
      logic signed [67:0] pw, sx, sy, sc, sr;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      x = {2'b00, ua & mask};
      y = {2'b00, ub & mask};
      if (sb) begin
         r    = x - y - 66'(ci);
         m.co = (x >= y + 66'(ci));
      end else begin
         r    = x + y + 66'(ci);
         m.co = r[w];
      end
      m.sum = r[63:0] & mask;
      pw = 68'sd1 <<< w;
      sx = $signed({2'b00, x});
      if (x[w-1]) sx = sx - pw;
      sy = $signed({2'b00, y});
      if (y[w-1]) sy = sy - pw;
      sc = $signed({67'd0, ci});
      sr = sb ? (sx - sy - sc) : (sx + sy + sc);
      m.ov  = (sr >= (pw >>> 1)) || (sr < -(pw >>> 1));
      m.acc = acc;
      return m;
   endfunction

   // ---------------- main 32-bit / 4-stage instance ----------------
   logic         rst, validin, in_allow, carry_in, sub, out_allow;
   logic [W-1:0] op_a, op_b, sum_out;
   logic [S-1:0] suspend, refresh;
   logic         validout, carry_out, overflow;

   pipeline_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .validin   (validin),
      .in_allow  (in_allow),
      .a         (op_a),
      .b         (op_b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_allow (out_allow),
      .suspend   (suspend),
      .refresh   (refresh),
      .validout  (validout),
      .sum_out   (sum_out),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   exp_t exp_q[$];
   int   pop_log[$];
   bit   chk_lat = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (validout && out_allow) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            check("sum_out", 64'(sum_out), e.sum);
            check("carry_out", 64'(carry_out), 64'(e.co));
            check("overflow", 64'(overflow), 64'(e.ov));
            if (chk_lat) check("latency", 64'(cyc - e.acc), 64'(S));
            pop_log.push_back(cyc);
         end
      end else if (validout && exp_q.size() != 0) begin
         check("held_sum", 64'(sum_out), exp_q[0].sum);
      end
   end

   // Present one op until accepted; returns the acceptance cycle, or -1 on timeout.
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic ts, output int acc);
      validin  = 1'b1;
      op_a     = ta;
      op_b     = tb;
      carry_in = tc;
      sub      = ts;
      acc      = -1;
      for (int k = 0; k < 100 && acc < 0; k++) begin
         @(negedge clk);
         if (in_allow) begin
            acc = cyc;
            exp_q.push_back(model(W, 64'(ta), 64'(tb), tc, ts, cyc));
         end
         @(posedge clk);
         #1;
      end
      validin = 1'b0;
      if (acc < 0) check("send_accepted", 64'(acc), 64'd0);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc_a, acc;
      int lat;
      bit rdone;
      rst = 1'b1; validin = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
      out_allow = 1'b1; suspend = '0; refresh = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_validout", 64'(validout), 64'd0);
      check("rst_sum_out", 64'(sum_out), 64'd0);
      check("rst_carry_out", 64'(carry_out), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_in_allow", 64'(in_allow), 64'd1);
      @(posedge clk);
      #1;

      // Directed corner operations, latency checked on each.
      chk_lat = 1'b1;
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, acc);
      send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, acc);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, acc);
      send(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, acc);
      drain("directed");

      // Back-to-back stream with operands changing every cycle.
      pop_log.delete();
      for (int i = 0; i < 8; i++) send(32'(i + 16), 32'(i), 1'b0, 1'b0, acc);
      drain("stream");
      check("stream_count", 64'(pop_log.size()), 64'd8);
      if (pop_log.size() == 8) check("stream_consecutive", 64'(pop_log[7] - pop_log[0]), 64'd7);
      chk_lat = 1'b0;

      // Backpressure: consumer stalls 6 cycles while the producer keeps pushing.
      fork
         begin
            int t;
            for (int i = 0; i < 12; i++) send(32'(i * 3 + 1), 32'($urandom), 1'b0, 1'(i), t);
         end
         begin
            out_allow = 1'b0;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               if (k == 5) begin
                  check("bp_in_allow_low", 64'(in_allow), 64'd0);
                  check("bp_validout_held", 64'(validout), 64'd1);
               end
               @(posedge clk);
               #1;
            end
            out_allow = 1'b1;
         end
      join
      drain("backpressure");

      // Stall stage 2 for two cycles while op A sits there; op B waits in stage 1.
      send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, acc_a);
      send(32'hCAFE_0000, 32'h0000_BEEF, 1'b1, 1'b1, acc);
      suspend = 4'b0010;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      suspend = '0;
      lat = -1;
      for (int k = 0; k < 30 && lat < 0; k++) begin
         @(negedge clk);
         if (validout) lat = cyc - acc_a;
      end
      check("suspend_latency", 64'(lat), 64'(S + 2));
      @(posedge clk);
      #1;
      drain("suspend");

      // Flush stage 3 as stage 2 forwards op B into it: B must vanish, A and C survive.
      send(32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0, acc);
      send(32'h0000_00BB, 32'h0000_0022, 1'b0, 1'b0, acc);
      send(32'h0000_00CC, 32'h0000_0033, 1'b0, 1'b0, acc);
      refresh = 4'b0100;
      exp_q.delete(exp_q.size() - 2);
      @(posedge clk);
      #1;
      refresh = '0;
      pop_log.delete();
      drain("refresh");
      check("refresh_result_count", 64'(pop_log.size()), 64'd2);

      // Random traffic with random backpressure and stalls.
      rdone = 1'b0;
      fork
         begin
            logic [W-1:0] ra, rb;
            int t;
            for (int i = 0; i < 150; i++) begin
               case ($urandom_range(0, 3))
                  0:       ra = 32'h8000_0000;
                  1:       ra = 32'hFFFF_FFFF;
                  default: ra = $urandom;
               endcase
               rb = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
               send(ra, rb, 1'($urandom), 1'($urandom), t);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               out_allow = ($urandom_range(0, 3) != 0);
               suspend   = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
            end
         end
      join
      out_allow = 1'b1;
      suspend   = '0;
      drain("random");

      // Reset with ops in flight: everything is discarded.
      for (int i = 0; i < 3; i++) send(32'(i + 100), 32'(i), 1'b0, 1'b0, acc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_validout", 64'(validout), 64'd0);
      check("midrst_in_allow", 64'(in_allow), 64'd1);
      check("midrst_sum_out", 64'(sum_out), 64'd0);
      repeat (8) @(posedge clk);
      #1;

      for (int k = 0; k < 20000 && !(g_var[0].done && g_var[1].done); k++) @(posedge clk);
      check("variants_done", {62'd0, g_var[1].done, g_var[0].done}, 64'd3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- parameter variants: 64/8 and 16/1 ----------------
   for (genvar g = 0; g < 2; g++) begin : g_var
      localparam int VW = (g == 0) ? 64 : 16;
      localparam int VS = (g == 0) ? 8 : 1;

      logic          vrst = 1'b1;
      logic          vvalid = 1'b0;
      logic          vin_allow, vvalidout, vcarry, vovf;
      logic [VW-1:0] va = '0, vb = '0, vsum;
      logic          vc = 1'b0, vs = 1'b0, voa = 1'b1;
      logic [VS-1:0] vsusp = '0, vref = '0;
      bit            done = 1'b0;
      exp_t          vq[$];

      pipeline_addsub #(.WIDTH(VW), .STAGES(VS)) dut_v (
         .clk       (clk),
         .rst       (vrst),
         .validin   (vvalid),
         .in_allow  (vin_allow),
         .a         (va),
         .b         (vb),
         .carry_in  (vc),
         .sub       (vs),
         .out_allow (voa),
         .suspend   (vsusp),
         .refresh   (vref),
         .validout  (vvalidout),
         .sum_out   (vsum),
         .carry_out (vcarry),
         .overflow  (vovf)
      );

      always @(posedge clk) begin
         #1;
         voa = ($urandom_range(0, 3) != 0);
      end

      always @(negedge clk) begin
         exp_t e;
         if (vvalidout && voa) begin
            if (vq.size() == 0) begin
               check($sformatf("v%0d_unexpected_result", g), 64'(vq.size()), 64'd1);
            end else begin
               e = vq.pop_front();
               check($sformatf("v%0d_sum", g), 64'(vsum), e.sum);
               check($sformatf("v%0d_carry", g), 64'(vcarry), 64'(e.co));
               check($sformatf("v%0d_overflow", g), 64'(vovf), 64'(e.ov));
            end
         end
      end

      initial begin
         logic [63:0] ra, rb;
         repeat (2) @(posedge clk);
         #1;
         vrst = 1'b0;
         for (int n = 0; n < 120; n++) begin
            if (n == 70) begin
               vvalid = 1'b0;
               vrst   = 1'b1;
               @(posedge clk);
               #1;
               vq.delete();
               vrst = 1'b0;
               @(negedge clk);
               check($sformatf("v%0d_midrst_validout", g), 64'(vvalidout), 64'd0);
               @(posedge clk);
               #1;
            end
            ra     = {$urandom, $urandom};
            rb     = ($urandom_range(0, 4) == 0) ? ~64'd0 : {$urandom, $urandom};
            va     = VW'(ra);
            vb     = VW'(rb);
            vc     = 1'($urandom);
            vs     = 1'($urandom);
            vvalid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (vvalid && vin_allow) vq.push_back(model(VW, 64'(va), 64'(vb), vc, vs, cyc));
            @(posedge clk);
            #1;
         end
         vvalid = 1'b0;
         for (int k = 0; k < 300 && vq.size() != 0; k++) begin
            @(posedge clk);
            #1;
         end
         check($sformatf("v%0d_drained", g), 64'(vq.size()), 64'd0);
         done = 1'b1;
      end
   end

endmodule
